// File: rtl/fft_input_framer.sv
`default_nettype none
// ============================================================================
// Module   : fft_input_framer
// Purpose  : Collects a complex sample stream into 16-sample frames
//            (bit-reversed slot order) in a ping-pong buffer and presents each
//            frame as a parallel vector to the FFT core.
// Revision : 1.0  initial release
// ============================================================================
module fft_input_framer #(
    parameter int DW          = 16,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_r,
    input  logic [DW-1:0]    in_i,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16*DW-1:0] out_r,
    output logic [16*DW-1:0] out_i,
    output logic             frame_err
);

    localparam int NSLOT = 16;

    logic [3:0]    r_cnt;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [1:0]    r_full;
    logic          r_frame_err;
    logic [DW-1:0] r_bank_r [2][NSLOT];
    logic [DW-1:0] r_bank_i [2][NSLOT];

    logic       w_accept;
    logic       w_handoff;
    logic       w_complete;
    logic [3:0] w_slot;
    logic [1:0] w_set;
    logic [1:0] w_clr;

    assign in_ready   = rst_n && !r_full[r_wr_bank];
    assign out_valid  = r_full[r_rd_bank];
    assign frame_err  = r_frame_err;

    assign w_accept   = in_valid && in_ready;
    assign w_handoff  = out_valid && out_ready;
    assign w_complete = w_accept && (r_cnt == 4'd15);
    assign w_slot     = BIT_REVERSE ? {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]} : r_cnt;

    // Completion and handoff always hit different banks, so set/clear masks
    // can be merged without priority concerns.
    assign w_set = w_complete ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr = w_handoff  ? (2'b01 << r_rd_bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_full      <= 2'b00;
            r_frame_err <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < NSLOT; k++) begin
                    r_bank_r[b][k] <= '0;
                    r_bank_i[b][k] <= '0;
                end
            end
        end else begin
            r_frame_err <= 1'b0;
            r_full      <= (r_full | w_set) & ~w_clr;
            if (w_accept) begin
                r_bank_r[r_wr_bank][w_slot] <= in_r;
                r_bank_i[r_wr_bank][w_slot] <= in_i;
                if (r_cnt == 4'd15) begin
                    r_wr_bank   <= ~r_wr_bank;
                    r_cnt       <= 4'd0;
                    r_frame_err <= !in_last;
                end else if (in_last) begin
                    // Early end of frame: drop the partial frame, keep the bank.
                    r_cnt       <= 4'd0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
            if (w_handoff) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    for (genvar k = 0; k < NSLOT; k++) begin : g_pack
        assign out_r[DW*k +: DW] = r_bank_r[r_rd_bank][k];
        assign out_i[DW*k +: DW] = r_bank_i[r_rd_bank][k];
    end

endmodule
`default_nettype wire
